// File: rtl/data_mem_channel_server.sv
// Multi-channel backing RAM: per-channel valid/ready ops with fixed READ/WRITE_LATENCY; ready holds until valid drops.
// Registered host side-port. Define MEM_STATS_EN to enable saturating completed-op counters.
module data_mem_channel_server #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CHANNELS  = 4,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic [NUM_CHANNELS-1:0]                i_mem_read_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] i_mem_read_address,
    output logic [NUM_CHANNELS-1:0]                o_mem_read_ready,
    output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] o_mem_read_data,
    input  logic [NUM_CHANNELS-1:0]                i_mem_write_valid,
    input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] i_mem_write_address,
    input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] i_mem_write_data,
    output logic [NUM_CHANNELS-1:0]                o_mem_write_ready,
    input  logic                                   i_host_write_enable,
    input  logic [ADDR_BITS-1:0]                   i_host_address,
    input  logic [DATA_BITS-1:0]                   i_host_write_data,
    output logic [DATA_BITS-1:0]                   o_host_read_data,
    output logic [15:0]                            o_stat_reads,
    output logic [15:0]                            o_stat_writes
);

    localparam int DEPTH   = 2 ** ADDR_BITS;
    localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WRITE_LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [DATA_BITS-1:0]                   r_mem [0:DEPTH-1];
    logic [NUM_CHANNELS-1:0][1:0]           r_state;
    logic [NUM_CHANNELS-1:0]                r_op_wr;
    logic [NUM_CHANNELS-1:0][CNT_W-1:0]     r_cnt;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] r_addr;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] r_wdata;
    logic [NUM_CHANNELS-1:0]                r_rd_rdy;
    logic [NUM_CHANNELS-1:0]                r_wr_rdy;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] r_rd_data;
    logic [DATA_BITS-1:0]                   r_host_rd;

    logic [NUM_CHANNELS-1:0]                w_commit;
    logic [NUM_CHANNELS-1:0]                w_commit_wr;

    // An op commits on the cycle its countdown expires; reset suppresses it.
    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_commit[ch] = i_reset && (r_state[ch] == S_WAIT) && (r_cnt[ch] == '0);
        end
        w_commit_wr = w_commit & r_op_wr;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= '0;
            r_op_wr   <= '0;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rd_rdy  <= '0;
            r_wr_rdy  <= '0;
            r_rd_data <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (r_state[ch])
                    S_IDLE: begin
                        if (i_mem_read_valid[ch]) begin
                            r_addr[ch]  <= i_mem_read_address[ch];
                            r_op_wr[ch] <= 1'b0;
                            r_cnt[ch]   <= RD_CNT_INIT;
                            r_state[ch] <= S_WAIT;
                        end else if (i_mem_write_valid[ch]) begin
                            r_addr[ch]  <= i_mem_write_address[ch];
                            r_wdata[ch] <= i_mem_write_data[ch];
                            r_op_wr[ch] <= 1'b1;
                            r_cnt[ch]   <= WR_CNT_INIT;
                            r_state[ch] <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (r_cnt[ch] == '0) begin
                            r_state[ch] <= S_RESP;
                            if (r_op_wr[ch]) begin
                                r_wr_rdy[ch] <= 1'b1;
                            end else begin
                                r_rd_rdy[ch]  <= 1'b1;
                                r_rd_data[ch] <= r_mem[r_addr[ch]];
                            end
                        end else begin
                            r_cnt[ch] <= r_cnt[ch] - 1'b1;
                        end
                    end
                    S_RESP: begin
                        // Response is held until the requester drops the matching valid.
                        if (r_op_wr[ch] ? !i_mem_write_valid[ch] : !i_mem_read_valid[ch]) begin
                            r_rd_rdy[ch] <= 1'b0;
                            r_wr_rdy[ch] <= 1'b0;
                            r_state[ch]  <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state[ch] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // Later assignments take precedence: host first, then channels in ascending index.
    always_ff @(posedge i_clk) begin
        if (i_host_write_enable) begin
            r_mem[i_host_address] <= i_host_write_data;
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (w_commit_wr[ch]) begin
                r_mem[r_addr[ch]] <= r_wdata[ch];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_host_rd <= '0;
        end else begin
            r_host_rd <= r_mem[i_host_address];
        end
    end

    assign o_mem_read_ready  = r_rd_rdy;
    assign o_mem_write_ready = r_wr_rdy;
    assign o_mem_read_data   = r_rd_data;
    assign o_host_read_data  = r_host_rd;

`ifdef MEM_STATS_EN
    logic [15:0] r_stat_reads;
    logic [15:0] r_stat_writes;
    logic [16:0] w_rd_inc;
    logic [16:0] w_wr_inc;
    logic [16:0] w_rd_sum;
    logic [16:0] w_wr_sum;

    always_comb begin
        w_rd_inc = '0;
        w_wr_inc = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            w_rd_inc = w_rd_inc + 17'(w_commit[ch] & ~r_op_wr[ch]);
            w_wr_inc = w_wr_inc + 17'(w_commit_wr[ch]);
        end
        w_rd_sum = {1'b0, r_stat_reads} + w_rd_inc;
        w_wr_sum = {1'b0, r_stat_writes} + w_wr_inc;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
        end else begin
            r_stat_reads  <= w_rd_sum[16] ? 16'hFFFF : w_rd_sum[15:0];
            r_stat_writes <= w_wr_sum[16] ? 16'hFFFF : w_wr_sum[15:0];
        end
    end

    assign o_stat_reads  = r_stat_reads;
    assign o_stat_writes = r_stat_writes;
`else
    assign o_stat_reads  = 16'h0000;
    assign o_stat_writes = 16'h0000;
`endif

endmodule

// File: tb/tb_data_mem_channel_server.sv
// Directed bench for data_mem_channel_server (default parameters, latency 2).
module tb_data_mem_channel_server;

    localparam int NC = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic                   clk;
    logic                   rst_n;
    logic [NC-1:0]          rv;
    logic [NC-1:0][AB-1:0]  ra;
    logic [NC-1:0]          rrdy;
    logic [NC-1:0][DB-1:0]  rdat;
    logic [NC-1:0]          wv;
    logic [NC-1:0][AB-1:0]  wa;
    logic [NC-1:0][DB-1:0]  wd;
    logic [NC-1:0]          wrdy;
    logic                   hwe;
    logic [AB-1:0]          ha;
    logic [DB-1:0]          hwd;
    logic [DB-1:0]          hrd;
    logic [15:0]            st_rd;
    logic [15:0]            st_wr;

    int total = 0;
    int bad   = 0;

    data_mem_channel_server dut (
        .i_clk               (clk),
        .i_reset             (rst_n),
        .i_mem_read_valid    (rv),
        .i_mem_read_address  (ra),
        .o_mem_read_ready    (rrdy),
        .o_mem_read_data     (rdat),
        .i_mem_write_valid   (wv),
        .i_mem_write_address (wa),
        .i_mem_write_data    (wd),
        .o_mem_write_ready   (wrdy),
        .i_host_write_enable (hwe),
        .i_host_address      (ha),
        .i_host_write_data   (hwd),
        .o_host_read_data    (hrd),
        .o_stat_reads        (st_rd),
        .o_stat_writes       (st_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [AB-1:0] a, input logic [DB-1:0] d);
        hwe = 1'b1;
        ha  = a;
        hwd = d;
        tick();
        hwe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        hwe = 1'b0; ha = '0; hwd = '0;
        tick();
        tick();
        chk("rst_rrdy", 32'(rrdy), 32'h0);
        chk("rst_wrdy", 32'(wrdy), 32'h0);
        chk("rst_rdat", 32'(rdat), 32'h0);
        chk("rst_hrd",  32'(hrd),  32'h0);
        chk("rst_strd", 32'(st_rd), 32'h0);
        chk("rst_stwr", 32'(st_wr), 32'h0);
        rst_n = 1'b1;

        // host preload then registered host read
        host_wr(8'h10, 8'hA5);
        tick();
        chk("host_rd_10", 32'(hrd), 32'hA5);

        // ch0 read 0x10, address change after acceptance is ignored
        rv[0] = 1'b1; ra[0] = 8'h10;
        tick();
        chk("t1_rrdy_t", 32'(rrdy[0]), 32'h0);
        ra[0] = 8'hFF;
        tick();
        chk("t1_rrdy_t1", 32'(rrdy[0]), 32'h0);
        tick();
        chk("t1_rrdy_t2", 32'(rrdy[0]), 32'h1);
        chk("t1_rdat", 32'(rdat[0]), 32'hA5);
        tick();
        chk("t1_hold_rdy", 32'(rrdy[0]), 32'h1);
        chk("t1_hold_dat", 32'(rdat[0]), 32'hA5);
        rv[0] = 1'b0;
        tick();
        chk("t1_drop", 32'(rrdy[0]), 32'h0);

        // ch1 write 0x20 <= 0x3C
        wv[1] = 1'b1; wa[1] = 8'h20; wd[1] = 8'h3C; ha = 8'h20;
        tick();
        tick();
        chk("t2_wrdy_t1", 32'(wrdy[1]), 32'h0);
        tick();
        chk("t2_wrdy_t2", 32'(wrdy[1]), 32'h1);
        tick();
        chk("t2_hrd", 32'(hrd), 32'h3C);
        chk("t2_wrdy_hold", 32'(wrdy[1]), 32'h1);
        wv[1] = 1'b0;
        tick();
        chk("t2_drop", 32'(wrdy[1]), 32'h0);

        // read wins over simultaneous write on one channel; write follows
        rv[0] = 1'b1; ra[0] = 8'h10;
        wv[0] = 1'b1; wa[0] = 8'h10; wd[0] = 8'h77;
        tick(); tick(); tick();
        chk("rw_rrdy", 32'(rrdy[0]), 32'h1);
        chk("rw_rdat", 32'(rdat[0]), 32'hA5);
        chk("rw_wrdy_lo", 32'(wrdy[0]), 32'h0);
        rv[0] = 1'b0;
        tick();
        chk("rw_rrdy_drop", 32'(rrdy[0]), 32'h0);
        tick(); tick();
        chk("rw_wrdy_early", 32'(wrdy[0]), 32'h0);
        tick();
        chk("rw_wrdy", 32'(wrdy[0]), 32'h1);
        wv[0] = 1'b0; ha = 8'h10;
        tick();
        chk("rw_mem10", 32'(hrd), 32'h77);

        // four channels read in the same cycle
        host_wr(8'h00, 8'h01);
        host_wr(8'h01, 8'h02);
        host_wr(8'h02, 8'h03);
        host_wr(8'h03, 8'h04);
        rv = 4'hF;
        ra[0] = 8'h00; ra[1] = 8'h01; ra[2] = 8'h02; ra[3] = 8'h03;
        tick(); tick();
        chk("t3_rrdy_t1", 32'(rrdy), 32'h0);
        tick();
        chk("t3_rrdy", 32'(rrdy), 32'hF);
        chk("t3_rdat", 32'(rdat), 32'h04030201);
        rv = '0;
        tick();
        chk("t3_drop", 32'(rrdy), 32'h0);

        // same-row collisions: highest channel wins, concurrent read sees old value
        host_wr(8'h40, 8'h5A);
        wv[0] = 1'b1; wa[0] = 8'h40; wd[0] = 8'h11;
        wv[3] = 1'b1; wa[3] = 8'h40; wd[3] = 8'h33;
        rv[2] = 1'b1; ra[2] = 8'h40;
        tick(); tick(); tick();
        chk("t4_wrdy", 32'(wrdy), 32'h9);
        chk("t4_rrdy", 32'(rrdy), 32'h4);
        chk("t4_old", 32'(rdat[2]), 32'h5A);
        wv = '0; rv = '0; ha = 8'h40;
        tick();
        chk("t4_mem40", 32'(hrd), 32'h33);
        chk("t4_wrdy_drop", 32'(wrdy), 32'h0);

        // channel write beats host write to the same row
        wv[2] = 1'b1; wa[2] = 8'h44; wd[2] = 8'hC2;
        tick(); tick();
        hwe = 1'b1; ha = 8'h44; hwd = 8'hEE;
        tick();
        hwe = 1'b0;
        wv[2] = 1'b0;
        tick();
        chk("chan_beats_host", 32'(hrd), 32'hC2);

        // reset during write WAIT drops the write
        host_wr(8'h50, 8'h12);
        wv[0] = 1'b1; wa[0] = 8'h50; wd[0] = 8'h77;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk("t5_wrdy", 32'(wrdy), 32'h0);
        chk("t5_rdat", 32'(rdat), 32'h0);
        chk("t5_hrd", 32'(hrd), 32'h0);
        wv = '0;
        tick();
        rst_n = 1'b1;
        ha = 8'h50;
        tick();
        chk("t5_host50", 32'(hrd), 32'h12);
        rv[0] = 1'b1; ra[0] = 8'h50;
        tick(); tick(); tick();
        chk("t5_rrdy", 32'(rrdy[0]), 32'h1);
        chk("t5_rdat50", 32'(rdat[0]), 32'h12);
        rv = '0;
        tick();

        // statistics: 3 reads + 2 writes after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        rv = 4'h7; ra[0] = 8'h00; ra[1] = 8'h01; ra[2] = 8'h02;
        wv[3] = 1'b1; wa[3] = 8'h60; wd[3] = 8'h09;
        tick(); tick(); tick();
        rv = '0; wv = '0;
        tick();
        wv[1] = 1'b1; wa[1] = 8'h61; wd[1] = 8'h08;
        tick(); tick(); tick();
        wv = '0;
        tick();
`ifdef MEM_STATS_EN
        chk("t6_strd", 32'(st_rd), 32'd3);
        chk("t6_stwr", 32'(st_wr), 32'd2);
`else
        chk("t6_strd", 32'(st_rd), 32'd0);
        chk("t6_stwr", 32'(st_wr), 32'd0);
`endif
        ha = 8'h61;
        tick();
        chk("t6_mem61", 32'(hrd), 32'h08);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
